// File: rtl/ft245_pkg.sv
`timescale 1ns/1ps
// Shared types for the FT245 async responder: FSM state encodings and the
// depth of the pin synchronizers.
package ft245_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AVAIL,
    R_READ,
    R_RECOVER
  } rd_state_t;

  typedef enum logic [1:0] {
    W_FULL,
    W_READY,
    W_BUSY,
    W_RECOVER
  } wr_state_t;

endpackage

// File: rtl/ft245_byte_fifo.sv
`timescale 1ns/1ps
// Synchronous byte FIFO with first-word-fallthrough read data; pushes while
// full and pops while empty are ignored.
module ft245_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ft245_async_responder.sv
`timescale 1ns/1ps
// Device side of an FT245-style async FIFO link: offers local bytes to the
// host via RXF#/RD# and streams host-written bytes (WR#/TXE#) to a local sink.
module ft245_async_responder
  import ft245_pkg::*;
#(
  parameter int FIFO_DEPTH        = 16,
  parameter int RXF_RECOVER_TICKS = 3,
  parameter int TXE_RECOVER_TICKS = 3
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic [7:0] rx_data_in,
  input  logic       rx_data_valid_in,
  output logic       rx_ready_out,
  output logic [7:0] tx_data_out,
  output logic       tx_data_valid_out,
  input  logic       tx_ready_in,
  output logic [1:0] err_out,
  inout  wire  [7:0] ft245_d_inout,
  output logic       ft245_nrxf_out,
  output logic       ft245_ntxe_out,
  input  logic       ft245_nrd_in,
  input  logic       ft245_nwr_in
);

  localparam int CW = 8;
  localparam logic [CW-1:0] RXF_LOAD = CW'(RXF_RECOVER_TICKS - 1);
  localparam logic [CW-1:0] TXE_LOAD = CW'(TXE_RECOVER_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0]      nrd_sync;
  logic [SYNC_STAGES-1:0]      nwr_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;
  logic                        nrd_last;
  logic                        nwr_last;
  logic                        nrd_s;
  logic                        nwr_s;
  logic                        nrd_fall;
  logic                        nrd_rise;
  logic                        nwr_fall;
  logic                        nwr_rise;
  logic [7:0]                  d_cap;

  // Strobes idle high, so the chains reset to 1 to avoid a false edge on release.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      nrd_sync <= '1;
      nwr_sync <= '1;
      d_sync   <= '0;
      nrd_last <= 1'b1;
      nwr_last <= 1'b1;
    end else begin
      nrd_sync <= {nrd_sync[SYNC_STAGES-2:0], ft245_nrd_in};
      nwr_sync <= {nwr_sync[SYNC_STAGES-2:0], ft245_nwr_in};
      d_sync   <= {d_sync[SYNC_STAGES-2:0], ft245_d_inout};
      nrd_last <= nrd_s;
      nwr_last <= nwr_s;
    end
  end

  assign nrd_s    = nrd_sync[SYNC_STAGES-1];
  assign nwr_s    = nwr_sync[SYNC_STAGES-1];
  assign d_cap    = d_sync[SYNC_STAGES-1];
  assign nrd_fall = nrd_last && !nrd_s;
  assign nrd_rise = !nrd_last && nrd_s;
  assign nwr_fall = nwr_last && !nwr_s;
  assign nwr_rise = !nwr_last && nwr_s;

  logic       rx_up;
  logic       rx_full;
  logic       rx_empty;
  logic [7:0] rx_fifo_data;
  logic [7:0] rx_head;
  logic       rx_head_valid;
  logic       head_load;
  logic       rd_pop;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) rx_up <= 1'b0;
    else          rx_up <= 1'b1;
  end

  assign rx_ready_out = rx_up && !rx_full;
  assign head_load    = !rx_head_valid && !rx_empty;

  ft245_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .push      (rx_data_valid_in && rx_ready_out),
    .push_data (rx_data_in),
    .pop       (head_load),
    .head_data (rx_fifo_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // The head register is what the bus shows; it refills as soon as it is consumed.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rx_head       <= '0;
      rx_head_valid <= 1'b0;
    end else if (head_load) begin
      rx_head       <= rx_fifo_data;
      rx_head_valid <= 1'b1;
    end else if (rd_pop) begin
      rx_head_valid <= 1'b0;
    end
  end

  assign ft245_d_inout = (!ft245_nrd_in && !reset_in) ? rx_head : 8'bz;

  rd_state_t     rd_state;
  logic [CW-1:0] rd_cnt;
  logic          nrxf;
  logic          err_rd;

  assign rd_pop = (rd_state == R_READ) && nrd_rise;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_state <= R_IDLE;
      rd_cnt   <= '0;
      nrxf     <= 1'b1;
      err_rd   <= 1'b0;
    end else begin
      if (nrd_fall && rd_state != R_AVAIL) err_rd <= 1'b1;
      case (rd_state)
        R_IDLE: begin
          if (rx_head_valid) begin
            rd_state <= R_AVAIL;
            nrxf     <= 1'b0;
          end
        end
        R_AVAIL: begin
          if (nrd_fall) rd_state <= R_READ;
        end
        R_READ: begin
          if (nrd_rise) begin
            rd_state <= R_RECOVER;
            rd_cnt   <= RXF_LOAD;
            nrxf     <= 1'b1;
          end
        end
        R_RECOVER: begin
          if (rd_cnt == '0) rd_state <= R_IDLE;
          else              rd_cnt   <= rd_cnt - CNT_ONE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  logic tx_full;
  logic tx_empty;
  logic tx_push;

  ft245_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_in    (clk_in),
    .reset_in  (reset_in),
    .push      (tx_push),
    .push_data (d_cap),
    .pop       (tx_data_valid_out && tx_ready_in),
    .head_data (tx_data_out),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  assign tx_data_valid_out = !tx_empty;

  wr_state_t     wr_state;
  logic [CW-1:0] wr_cnt;
  logic          ntxe;
  logic          err_wr;

  // The data synchronizer matches the strobe path, so d_cap is the byte seen with WR# falling.
  assign tx_push = (wr_state == W_READY) && nwr_fall;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_state <= W_FULL;
      wr_cnt   <= '0;
      ntxe     <= 1'b1;
      err_wr   <= 1'b0;
    end else begin
      if (nwr_fall && wr_state != W_READY) err_wr <= 1'b1;
      case (wr_state)
        W_FULL: begin
          if (!tx_full) begin
            wr_state <= W_READY;
            ntxe     <= 1'b0;
          end
        end
        W_READY: begin
          if (nwr_fall) begin
            wr_state <= W_BUSY;
            ntxe     <= 1'b1;
          end
        end
        W_BUSY: begin
          if (nwr_rise) begin
            wr_state <= W_RECOVER;
            wr_cnt   <= TXE_LOAD;
          end
        end
        W_RECOVER: begin
          if (wr_cnt != '0) begin
            wr_cnt <= wr_cnt - CNT_ONE;
          end else if (tx_full) begin
            wr_state <= W_FULL;
          end else begin
            wr_state <= W_READY;
            ntxe     <= 1'b0;
          end
        end
        default: wr_state <= W_FULL;
      endcase
    end
  end

  assign ft245_nrxf_out = nrxf;
  assign ft245_ntxe_out = ntxe;
  assign err_out        = {err_wr, err_rd};

endmodule

// File: tb/tb_ft245_async_responder.sv
`timescale 1ns/1ps
// Self-checking bench for ft245_async_responder: a host model drives RD#/WR#,
// and queue-based reference models track the RX and TX byte streams.
module tb_ft245_async_responder;

  localparam int RXF_REC = 3;
  localparam int TXE_REC = 3;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] rx_data_in;
  logic       rx_data_valid_in;
  logic       rx_ready_out;
  logic [7:0] tx_data_out;
  logic       tx_data_valid_out;
  logic       tx_ready_in;
  logic [1:0] err_out;
  wire  [7:0] d_bus;
  logic       nrxf;
  logic       ntxe;
  logic       nrd;
  logic       nwr;
  logic [7:0] host_d;
  logic       host_d_en;

  assign d_bus = host_d_en ? host_d : 8'bz;

  int errors = 0;
  int checks = 0;

  byte unsigned rx_model[$];
  byte unsigned tx_model[$];
  byte unsigned tx_seen[$];
  logic [1:0]   model_err;

  logic [7:0] got;
  logic       acc;
  logic       ok;
  int         accepted;

  ft245_async_responder #(
    .FIFO_DEPTH        (16),
    .RXF_RECOVER_TICKS (RXF_REC),
    .TXE_RECOVER_TICKS (TXE_REC)
  ) dut (
    .clk_in            (clk_in),
    .reset_in          (reset_in),
    .rx_data_in        (rx_data_in),
    .rx_data_valid_in  (rx_data_valid_in),
    .rx_ready_out      (rx_ready_out),
    .tx_data_out       (tx_data_out),
    .tx_data_valid_out (tx_data_valid_out),
    .tx_ready_in       (tx_ready_in),
    .err_out           (err_out),
    .ft245_d_inout     (d_bus),
    .ft245_nrxf_out    (nrxf),
    .ft245_ntxe_out    (ntxe),
    .ft245_nrd_in      (nrd),
    .ft245_nwr_in      (nwr)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // Sink side: every accepted TX byte must be the oldest one the host legally wrote.
  always @(negedge clk_in) begin
    if (!reset_in) begin
      if (tx_data_valid_out && tx_ready_in) begin
        if (tx_model.size() == 0) begin
          failNow("tx_unexpected_byte");
        end else begin
          checkOutput("tx_stream", tx_data_out, tx_model[0]);
          tx_seen.push_back(tx_data_out);
          void'(tx_model.pop_front());
        end
      end
      checkOutput("err_not_early", err_out & ~model_err, 2'b00);
    end
  end

  task automatic applyStimulus(input logic [7:0] b, output logic accepted_now);
    logic ready;
    rx_data_in       = b;
    rx_data_valid_in = 1'b1;
    @(negedge clk_in);
    ready = rx_ready_out;
    tick(1);
    rx_data_valid_in = 1'b0;
    if (ready) rx_model.push_back(b);
    accepted_now = ready;
  endtask

  task automatic hostRead(input int low_cyc, input int high_cyc, output logic [7:0] data, output logic done);
    int guard = 0;
    int rise = 0;
    int low_after = 0;
    logic [7:0] exp;
    data = 8'h00;
    done = 1'b0;
    while (nrxf !== 1'b0 && guard < 64) begin
      tick(1);
      guard++;
    end
    if (nrxf !== 1'b0) begin
      failNow("rxf_wait");
      return;
    end
    if (rx_model.size() == 0) begin
      failNow("rxf_low_with_nothing_queued");
      return;
    end
    exp = rx_model.pop_front();
    nrd = 1'b0;
    tick(low_cyc);
    data = d_bus;
    checkOutput("read_data", data, exp);
    checkOutput("rxf_low_during_read", nrxf, 1'b0);
    nrd = 1'b1;
    for (int c = 1; c <= high_cyc; c++) begin
      tick(1);
      if (rise == 0 && nrxf) rise = c;
      if (rise != 0 && low_after == 0 && !nrxf) low_after = c;
    end
    checkOutput("rxf_rise_latency", rise, 3);
    if (low_after != 0) checkOutput("rxf_recover_gap", low_after >= 3 + RXF_REC + 1, 1);
    done = 1'b1;
  endtask

  task automatic hostWrite(input logic [7:0] b, input int low_cyc, input bit wait_txe);
    int guard = 0;
    int rise = 0;
    logic legal;
    if (wait_txe) begin
      while (ntxe !== 1'b0 && guard < 64) begin
        tick(1);
        guard++;
      end
      if (ntxe !== 1'b0) begin
        failNow("txe_wait");
        return;
      end
    end
    legal     = (ntxe == 1'b0);
    host_d    = b;
    host_d_en = 1'b1;
    nwr       = 1'b0;
    if (legal) tx_model.push_back(b);
    else       model_err[1] = 1'b1;
    for (int c = 1; c <= low_cyc; c++) begin
      tick(1);
      if (c == 3) host_d_en = 1'b0;
      if (rise == 0 && ntxe) rise = c;
    end
    if (legal) checkOutput("txe_rise_latency", rise, 3);
    nwr       = 1'b1;
    host_d_en = 1'b0;
    tick(1);
  endtask

  task automatic badRead();
    checkOutput("rxf_high_before_bad_read", nrxf, 1'b1);
    model_err[0] = 1'b1;
    nrd = 1'b0;
    tick(4);
    nrd = 1'b1;
    tick(6);
  endtask

  task automatic drainTx(input int limit);
    int g = 0;
    while (tx_model.size() != 0 && g < limit) begin
      tick(1);
      g++;
    end
    checkOutput("tx_drain_complete", tx_model.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    byte unsigned wr3[3];
    wr3 = '{8'h11, 8'h22, 8'h33};
    reset_in = 1'b1; nrd = 1'b1; nwr = 1'b1; host_d = 8'h00; host_d_en = 1'b0;
    rx_data_in = 8'h00; rx_data_valid_in = 1'b0; tx_ready_in = 1'b0; model_err = 2'b00;

    tick(3);
    checkOutput("reset_nrxf", nrxf, 1'b1);
    checkOutput("reset_ntxe", ntxe, 1'b1);
    checkOutput("reset_tx_valid", tx_data_valid_out, 1'b0);
    checkOutput("reset_rx_ready", rx_ready_out, 1'b0);
    checkOutput("reset_err", err_out, 2'b00);
    reset_in = 1'b0;
    tick(1);
    checkOutput("post_reset_rx_ready", rx_ready_out, 1'b1);
    checkOutput("post_reset_ntxe", ntxe, 1'b0);

    $display("[TB] two reads of queued bytes");
    applyStimulus(8'hA5, acc);
    applyStimulus(8'h3C, acc);
    hostRead(5, 10, got, ok);
    checkOutput("read1_literal", got, 8'hA5);
    hostRead(5, 10, got, ok);
    checkOutput("read2_literal", got, 8'h3C);
    tick(10);
    checkOutput("rxf_idle_after_reads", nrxf, 1'b1);

    $display("[TB] three host writes with sink ready");
    tx_ready_in = 1'b1;
    tx_seen.delete();
    for (int i = 0; i < 3; i++) hostWrite(wr3[i], 5, 1'b1);
    drainTx(50);
    checkOutput("tx3_count", tx_seen.size(), 3);
    if (tx_seen.size() == 3) begin
      checkOutput("tx3_byte0", tx_seen[0], 8'h11);
      checkOutput("tx3_byte1", tx_seen[1], 8'h22);
      checkOutput("tx3_byte2", tx_seen[2], 8'h33);
    end

    $display("[TB] fill TX FIFO with sink stalled");
    tx_ready_in = 1'b0;
    tx_seen.delete();
    for (int i = 0; i < 16; i++) hostWrite(8'($urandom), $urandom_range(4, 7), 1'b1);
    tick(8);
    checkOutput("txe_high_when_full", ntxe, 1'b1);
    checkOutput("tx_valid_when_full", tx_data_valid_out, 1'b1);
    hostWrite(8'hEE, 5, 1'b0);
    tick(2);
    checkOutput("err_after_17th_write", err_out, 2'b10);
    for (int g = 0; g < 400 && tx_model.size() != 0; g++) begin
      tx_ready_in = 1'($urandom_range(0, 1));
      tick(1);
    end
    tx_ready_in = 1'b1;
    drainTx(40);
    checkOutput("tx16_count", tx_seen.size(), 16);
    tick(1);
    for (int g = 0; g < 20 && ntxe !== 1'b0; g++) tick(1);
    checkOutput("txe_low_after_drain", ntxe, 1'b0);

    $display("[TB] read strobe with nothing to read");
    badRead();
    checkOutput("err_after_bad_read", err_out, 2'b11);
    applyStimulus(8'h5A, acc);
    hostRead(5, 10, got, ok);
    checkOutput("read_5a_literal", got, 8'h5A);

    $display("[TB] overlapping read and write");
    applyStimulus(8'h77, acc);
    tx_seen.delete();
    fork
      hostWrite(8'h88, 8, 1'b1);
      begin
        tick(4);
        hostRead(5, 10, got, ok);
      end
    join
    drainTx(40);
    checkOutput("overlap_read_literal", got, 8'h77);
    checkOutput("overlap_write_count", tx_seen.size(), 1);
    if (tx_seen.size() == 1) checkOutput("overlap_write_literal", tx_seen[0], 8'h88);

    $display("[TB] fill RX side without reading");
    accepted = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'($urandom), acc);
      if (acc) accepted++;
    end
    checkOutput("rx_accepted_until_full", accepted, 17);
    checkOutput("rx_ready_when_full", rx_ready_out, 1'b0);
    for (int i = 0; i < 17 && rx_model.size() != 0; i++) begin
      hostRead($urandom_range(4, 7), $urandom_range(8, 12), got, ok);
      if (!ok) break;
    end
    checkOutput("rx_ready_after_empty", rx_ready_out, 1'b1);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: applyStimulus(8'($urandom), acc);
        1: if (nrxf == 1'b0) hostRead($urandom_range(4, 7), $urandom_range(8, 12), got, ok);
        2: if (ntxe == 1'b0) hostWrite(8'($urandom), $urandom_range(4, 7), 1'b1);
        default: begin
          tx_ready_in = 1'($urandom_range(0, 1));
          tick($urandom_range(1, 3));
        end
      endcase
    end
    tx_ready_in = 1'b1;
    drainTx(200);
    while (rx_model.size() != 0) begin
      hostRead($urandom_range(4, 7), $urandom_range(8, 12), got, ok);
      if (!ok) break;
    end
    checkOutput("random_rx_drained", rx_model.size(), 0);

    $display("[TB] reset during a read");
    tx_ready_in = 1'b0;
    hostWrite(8'hC1, 5, 1'b1);
    hostWrite(8'hC2, 5, 1'b1);
    applyStimulus(8'hD1, acc);
    applyStimulus(8'hD2, acc);
    for (int g = 0; g < 20 && nrxf !== 1'b0; g++) tick(1);
    nrd = 1'b0;
    tick(2);
    reset_in = 1'b1;
    rx_model.delete();
    tx_model.delete();
    model_err = 2'b00;
    #1;
    checkOutput("midreset_nrxf", nrxf, 1'b1);
    checkOutput("midreset_ntxe", ntxe, 1'b1);
    checkOutput("midreset_tx_valid", tx_data_valid_out, 1'b0);
    checkOutput("midreset_rx_ready", rx_ready_out, 1'b0);
    nrd = 1'b1;
    tick(2);
    reset_in = 1'b0;
    tick(10);
    checkOutput("after_reset_rx_flushed", nrxf, 1'b1);
    checkOutput("after_reset_tx_flushed", tx_data_valid_out, 1'b0);
    checkOutput("after_reset_ntxe", ntxe, 1'b0);
    checkOutput("after_reset_err", err_out, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
